mixcolumns_col: RTL
===================

Name: mixcolumns_col

Overview:
- Downstream neighbour of the SubBytes stage in the iterative AES core.
- Takes one 32-bit substituted column and applies AES MixColumns, or InvMixColumns when decrypt is selected.
- Computes one output byte per clock, so a column takes 4 cycles, and signals completion with a one-cycle ready pulse.
- Shares the SubBytes start/ready handshake style, so the round controller can chain the two stages directly.

Parameters:
HOLD_OUTPUT, 1, 1: data_o holds the last result until the next completion; 0: data_o reads 0 whenever ready_o is low.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset; sampled on rising edge of clk
start_i  input  1  request to process data_i; sampled only in IDLE
decrypt_i  input  1  1 = InvMixColumns; latched with start_i
data_i  input  32  column in; [31:24]=a0 (row 0) ... [7:0]=a3 (row 3)
ready_o  output  1  one-cycle pulse: data_o valid
data_o  output  32  column out, same byte order as data_i
busy_o  output  1  high while a column is in flight

Behaviour:
- Reset (reset low at a rising edge):
  - ready_o=0, data_o=0, busy_o=0.
  - State goes to IDLE and the byte counter to 0.
  - Input latch and partial-result register are cleared.
  - Reset mid-operation discards the in-flight column; no ready pulse is issued for it.
- States: IDLE, CALC. The byte counter cnt is 2 bits.
- IDLE:
  - start_i=1 at edge E0: latch data_i into a[0..3] and decrypt_i into mode.
  - Set cnt=0, go to CALC, busy_o=1.
  - start_i=0: stay in IDLE.
- CALC, at each edge:
  - Compute byte b[cnt] from the latched a[] and store it in the partial register.
  - Increment cnt.
- At the edge where cnt==3:
  - The full column {b0,b1,b2,b3} is written to data_o.
  - ready_o=1 for exactly one cycle.
  - State returns to IDLE and busy_o=0.
- Latency: start at E0 -> ready_o high after E4 (4 cycles). Back-to-back start is accepted at E5; sustained throughput is one column per 5 cycles.
- While in CALC:
  - start_i is ignored.
  - Changes on data_i/decrypt_i are ignored; only the latched values are used.
- Forward transform:
  - b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3.
- Inverse transform:
  - b0=14a0^11a1^13a2^9a3; rows 1-3 use the same coefficients rotated right by one per row.
- GF(2^8) arithmetic:
  - Polynomial 0x11B.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 0).
  - 3x = xtime(x)^x; 9x, 11x, 13x and 14x are built from xtime applied three times plus XOR.
  - All results are 8 bits, with no carry out.
- Coefficient selection: muxed by mode and cnt; one shared multiplier set per cycle.
- data_o when HOLD_OUTPUT=1: retains the value across idle cycles and across a following start, until the next completion.
- data_o when HOLD_OUTPUT=0: zeroed on the edge after the ready pulse.
- Simultaneous reset low and start_i high: reset wins.

Optional Feature:
MIXCOLUMNS_INVERSE_EN
- Defined:
  - decrypt_i is latched and selects InvMixColumns as above.
- Undefined:
  - Inverse coefficient logic is not built.
  - decrypt_i is ignored and the forward transform is always used.
  - Timing and handshake are identical in both builds.

Test Plan:
- Forward basic: reset low 2 cycles, release; start_i=1 for 1 cycle with data_i=32'hDB135345, decrypt_i=0 -> busy_o=1 for 4 cycles; ready_o pulses 4 cycles after start with data_o=32'h8E4DA1BC.
- Forward vectors:
  - F20A225C -> 9FDC589D.
  - 01010101 -> 01010101.
  - C6C6C6C6 -> C6C6C6C6.
  - Run back-to-back, each start issued the cycle after ready_o -> results in order, one per 5 cycles.
- Inverse (MIXCOLUMNS_INVERSE_EN defined): data_i=32'h8E4DA1BC, decrypt_i=1 -> data_o=32'hDB135345.
  - Without the macro, the same stimulus yields the forward result of 8E4DA1BC.
- Busy ignore: start_i=1 held continuously with data_i changing every cycle -> a new column is accepted only in the cycle after each ready_o pulse; each output matches the data_i value sampled at its accepting edge.
- Reset mid-operation: start with DB135345, assert reset at cycle 2 of CALC -> no ready_o pulse; data_o=0, busy_o=0.
  - A next start of F20A225C after release -> 9FDC589D.
- HOLD_OUTPUT=0: after a completion, data_o returns to 0 the next cycle.
- HOLD_OUTPUT=1: data_o keeps 8E4DA1BC through 10 idle cycles.

Source files
------------

// File: rtl/mixcolumns_col_if.sv
// Start/ready handshake bundle for the MixColumns column stage.
// The master drives a column in; the slave returns the mixed column with a ready pulse.
interface mixcolumns_col_if;
  logic        start_i;
  logic        decrypt_i;
  logic [31:0] data_i;
  logic        ready_o;
  logic [31:0] data_o;
  logic        busy_o;

  modport master (
    output start_i, decrypt_i, data_i,
    input  ready_o, data_o, busy_o
  );

  modport slave (
    input  start_i, decrypt_i, data_i,
    output ready_o, data_o, busy_o
  );
endinterface

// File: rtl/mixcolumns_col.sv
// AES MixColumns / InvMixColumns on one 32-bit column, one output byte per clock.
// Optional macro MIXCOLUMNS_INVERSE_EN builds the inverse transform selected by decrypt_i.
module mixcolumns_col #(
  parameter int HOLD_OUTPUT = 1
) (
  input logic             clk,
  input logic             reset,
  mixcolumns_col_if.slave bus
);

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state;
  logic [1:0]       cnt;
  logic [0:3][7:0]  a;
  logic [23:0]      partial;
  logic [3:0][7:0]  op;
  logic [3:0][7:0]  d2;
  logic [7:0]       fwd_byte;
  logic [7:0]       b_byte;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // Rotating the operands by cnt lets each row reuse the row-0 coefficient set.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      op[k] = a[2'(cnt + 2'(k))];
      d2[k] = xtime(op[k]);
    end
    fwd_byte = d2[0] ^ d2[1] ^ op[1] ^ op[2] ^ op[3];
  end

`ifdef MIXCOLUMNS_INVERSE_EN
  logic             mode;
  logic [3:0][7:0]  d4;
  logic [3:0][7:0]  d8;
  logic [7:0]       inv_byte;

  // Inverse coefficients 14, 11, 13, 9 decomposed into the 8x/4x/2x/1x terms.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      d4[k] = xtime(d2[k]);
      d8[k] = xtime(d4[k]);
    end
    inv_byte = (d8[0] ^ d4[0] ^ d2[0]) ^
               (d8[1] ^ d2[1] ^ op[1]) ^
               (d8[2] ^ d4[2] ^ op[2]) ^
               (d8[3] ^ op[3]);
    b_byte   = mode ? inv_byte : fwd_byte;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode <= 1'b0;
    end else if (state == IDLE && bus.start_i) begin
      mode <= bus.decrypt_i;
    end
  end
`else
  assign b_byte = fwd_byte;
`endif

  // Bytes b0..b2 collect in partial; the fourth byte completes the column directly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      a           <= '0;
      partial     <= '0;
      bus.ready_o <= 1'b0;
      bus.data_o  <= '0;
      bus.busy_o  <= 1'b0;
    end else begin
      bus.ready_o <= 1'b0;
      if (HOLD_OUTPUT == 0 && bus.ready_o) begin
        bus.data_o <= '0;
      end
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            a          <= bus.data_i;
            cnt        <= 2'd0;
            state      <= CALC;
            bus.busy_o <= 1'b1;
          end
        end
        CALC: begin
          cnt     <= cnt + 2'd1;
          partial <= {partial[15:0], b_byte};
          if (cnt == 2'd3) begin
            bus.data_o  <= {partial, b_byte};
            bus.ready_o <= 1'b1;
            bus.busy_o  <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
